// File: rtl/inst_queue_param.sv
// ---------------------------------------------------------------------------
// inst_queue_param
//
// Instruction queue sitting between the fetch (IF) and decode (ID) stages.
// It buffers {instruction, PC, predicted-taken} triples in a circular buffer
// of DEPTH entries. The head entry is presented first-word-fall-through, so
// decode sees it without waiting for a read cycle.
//
// Parameters:
//   DATA_W      instruction width in bits
//   PC_W        PC width in bits
//   DEPTH       number of entries; must be a power of two and >= 2
//   AFULL_SLACK almost_full_out asserts when free entries <= AFULL_SLACK
//               (0 .. DEPTH-1)
//
// Ports:
//   clk_in          rising-edge clock
//   rst_n_in        asynchronous active-low reset
//   rdy_in          global ready; 0 freezes transfers and the overflow flag
//   clear_in        synchronous flush on branch mispredict; wins over
//                   any push or pop in the same cycle
//   push_valid_in   fetch offers an entry
//   push_inst_in    offered instruction
//   push_pc_in      offered PC
//   push_pred_in    offered predicted-taken bit
//   push_ready_out  queue takes the offered entry this cycle
//   almost_full_out early back-pressure warning for fetch (ungated by rdy_in)
//   pop_valid_out   head entry is available to decode
//   pop_inst_out    head instruction
//   pop_pc_out      head PC
//   pop_pred_out    head predicted-taken bit
//   pop_ready_in    decode consumes the head this cycle
//   count_out       current occupancy (0 .. DEPTH)
//   ovf_sticky_out  fetch pushed into a full queue at least once since reset
// ---------------------------------------------------------------------------
module inst_queue_param #(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int DEPTH       = 16,
  parameter int AFULL_SLACK = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       clear_in,
  input  logic                       push_valid_in,
  input  logic [DATA_W-1:0]          push_inst_in,
  input  logic [PC_W-1:0]            push_pc_in,
  input  logic                       push_pred_in,
  output logic                       push_ready_out,
  output logic                       almost_full_out,
  output logic                       pop_valid_out,
  output logic [DATA_W-1:0]          pop_inst_out,
  output logic [PC_W-1:0]            pop_pc_out,
  output logic                       pop_pred_out,
  input  logic                       pop_ready_in,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       ovf_sticky_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Count values used for the full / almost-full comparisons.
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SLACK_CNT = CNT_W'(AFULL_SLACK);

  typedef struct packed {
    logic              pred;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               not_full;
  logic               not_empty;
  logic               push_fire;
  logic               pop_fire;
  logic               ovf_event;
  logic [CNT_W-1:0]   free_cnt;
  entry_t             push_entry;
  entry_t             head_entry;

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  assign not_full  = (count_q != FULL_CNT);
  assign not_empty = (count_q != '0);

  // Readiness is based on the registered count only: a pop in the same cycle
  // does not open a slot on a full queue, which keeps push_ready_out free of
  // any combinational path from pop_ready_in.
  assign push_ready_out = rdy_in & not_full  & ~clear_in;
  assign pop_valid_out  = rdy_in & not_empty & ~clear_in;

  assign push_fire = push_valid_in & push_ready_out;
  assign pop_fire  = pop_valid_out & pop_ready_in;

  // Fetch pushed while the queue could not take it; a flush or a frozen
  // pipeline is not counted as an overflow.
  assign ovf_event = rdy_in & push_valid_in & ~push_ready_out & ~clear_in;

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  assign free_cnt        = FULL_CNT - count_q;
  assign almost_full_out = (free_cnt <= SLACK_CNT);
  assign count_out       = count_q;
  assign ovf_sticky_out  = ovf_q;

  // -------------------------------------------------------------------------
  // Head data: asynchronous read of the storage (first-word-fall-through).
  // A freshly pushed entry is only visible after it lands in storage, so
  // there is no same-cycle bypass into an empty queue.
  // -------------------------------------------------------------------------
  assign head_entry   = mem_q[head_q];
  assign pop_inst_out = head_entry.inst;
  assign pop_pc_out   = head_entry.pc;
  assign pop_pred_out = head_entry.pred;

  assign push_entry = '{pred: push_pred_in, pc: push_pc_in, inst: push_inst_in};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a signal unassigned (no latch).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q | ovf_event;

    if (clear_in) begin
      // Flush wins over any transfer; the handshakes are already gated off,
      // so the overflow flag simply keeps its value.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are exactly PTR_W bits, so DEPTH-1 rolls over to 0 on its own.
      if (push_fire) tail_d = tail_q + PTR_W'(1);
      if (pop_fire)  head_d = head_q + PTR_W'(1);

      unique case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the entry array has no reset; its contents are only observed
  // through pop_valid_out, which is driven by the reset count. Leaving it
  // unreset lets it map onto plain flops or a register file.
  always_ff @(posedge clk_in) begin
    if (push_fire) begin
      mem_q[tail_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_inst_queue_param.sv
module tb_inst_queue_param;

  localparam int DATA_W      = 32;
  localparam int PC_W        = 32;
  localparam int DEPTH       = 4;
  localparam int AFULL_SLACK = 1;
  localparam int CNT_W       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rdy;
  logic              clear;
  logic              push_valid;
  logic [DATA_W-1:0] push_inst;
  logic [PC_W-1:0]   push_pc;
  logic              push_pred;
  logic              push_ready;
  logic              almost_full;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_inst;
  logic [PC_W-1:0]   pop_pc;
  logic              pop_pred;
  logic              pop_ready;
  logic [CNT_W-1:0]  count;
  logic              ovf_sticky;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_queue_param #(
    .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .AFULL_SLACK(AFULL_SLACK)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear_in(clear),
    .push_valid_in(push_valid), .push_inst_in(push_inst), .push_pc_in(push_pc),
    .push_pred_in(push_pred), .push_ready_out(push_ready),
    .almost_full_out(almost_full), .pop_valid_out(pop_valid),
    .pop_inst_out(pop_inst), .pop_pc_out(pop_pc), .pop_pred_out(pop_pred),
    .pop_ready_in(pop_ready), .count_out(count), .ovf_sticky_out(ovf_sticky)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [DATA_W-1:0] inst,
                       input logic [PC_W-1:0] pc, input logic pred,
                       input logic pr);
    push_valid = pv;
    push_inst  = inst;
    push_pc    = pc;
    push_pred  = pred;
    pop_ready  = pr;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rdy = 1'b1; clear = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
    checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf_sticky); end
  endtask

  // Plan item 1: fill to full, then overflow attempt.
  task automatic test_fill_overflow();
    logic [DATA_W-1:0] insts [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, insts[i], PC_W'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL fill3_count: got %0d want 3", count); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL fill3_afull: got %b want 1", almost_full); end
    checks++; if (pop_inst !== 32'h11) begin failures++; $display("FAIL fill3_head_inst: got %h want 11", pop_inst); end
    checks++; if (pop_pc !== 32'h0) begin failures++; $display("FAIL fill3_head_pc: got %h want 0", pop_pc); end
    tick();
    drive(1'b1, insts[3], 32'hC, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL full_push_ready: got %b want 0", push_ready); end
    checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL full_ovf_early: got %b want 0", ovf_sticky); end
    tick();
    drive(1'b1, 32'h55, 32'h10, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ovf_sticky); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count: got %0d want 4", count); end
    tick();
  endtask

  // Plan item 2: push+pop on a full queue only pops; then drain in order.
  task automatic test_full_push_pop();
    logic [DATA_W-1:0] rest [3] = '{32'h22, 32'h33, 32'h44};
    drive(1'b1, 32'h66, 32'h14, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL fullpp_push_ready: got %b want 0", push_ready); end
    checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL fullpp_pop_valid: got %b want 1", pop_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL fullpp_count: got %0d want 3", count); end
    checks++; if (pop_inst !== 32'h22) begin failures++; $display("FAIL fullpp_head: got %h want 22", pop_inst); end
    checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL fullpp_push_ready_after: got %b want 1", push_ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (pop_inst !== rest[i] || pop_pc !== PC_W'(4 * (i + 1)) || pop_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_%0d: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                 i, pop_valid, pop_inst, pop_pc, rest[i], 4 * (i + 1));
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_count: got %0d want 0", count); end
    tick();
  endtask

  // Plan item 3: continuous push/pop at occupancy 2 across pointer wrap.
  task automatic test_wrap();
    int next_push = 1;
    int next_pop  = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      logic pv, pr;
      pv = (next_push <= 10);
      pr = (cyc >= 2);
      drive(pv, DATA_W'(next_push), PC_W'(32'h100 + 4 * next_push), next_push[0], pr);
      @(negedge clk);
      if (pr) begin
        checks++;
        if (pop_valid !== 1'b1 || pop_inst !== DATA_W'(next_pop) ||
            pop_pc !== PC_W'(32'h100 + 4 * next_pop) || pop_pred !== next_pop[0]) begin
          failures++;
          $display("FAIL wrap_pop_%0d: got v=%b inst=%h pc=%h pred=%b want v=1 inst=%h pc=%h pred=%b",
                   next_pop, pop_valid, pop_inst, pop_pc, pop_pred,
                   next_pop, 32'h100 + 4 * next_pop, next_pop[0]);
        end
        next_pop++;
      end
      if (cyc >= 2 && cyc < 10) begin
        checks++;
        if (count !== 3'd2) begin failures++; $display("FAIL wrap_count_c%0d: got %0d want 2", cyc, count); end
      end
      if (pv) next_push++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_end_count: got %0d want 0", count); end
    tick();
  endtask

  // Plan item 4: no bypass into an empty queue.
  task automatic test_empty_no_bypass();
    drive(1'b1, 32'hAB, 32'h200, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL nobypass_valid: got %b want 0", pop_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b1 || pop_inst !== 32'hAB || pop_pred !== 1'b1) begin
      failures++;
      $display("FAIL nobypass_next: got v=%b inst=%h pred=%b want v=1 inst=ab pred=1", pop_valid, pop_inst, pop_pred);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL nobypass_consumed: got %0d want 0", count); end
    tick();
  endtask

  // Plan item 5: flush discards queued entries and same-cycle transfers.
  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DATA_W'(32'hC0 + i), PC_W'(32'h300 + 4 * i), 1'b0, 1'b0);
      tick();
    end
    clear = 1'b1;
    drive(1'b1, 32'hDD, 32'h400, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (push_ready !== 1'b0 || pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_gating: got push_ready=%b pop_valid=%b want 0 0", push_ready, pop_valid);
    end
    tick();
    clear = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL clear_count: got %0d want 0", count); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL clear_pop_valid: got %b want 0", pop_valid); end
    checks++; if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL clear_ovf_kept: got %b want 1", ovf_sticky); end
    tick();
    drive(1'b1, 32'h77, 32'h500, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (count !== 3'd1 || pop_inst !== 32'h77) begin
      failures++;
      $display("FAIL clear_after_push: got count=%0d head=%h want 1 77", count, pop_inst);
    end
    tick();
  endtask

  // Plan item 6: rdy_in freeze, then asynchronous reset mid-cycle.
  task automatic test_freeze_and_async_reset();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, DATA_W'(32'hE0 + i), PC_W'(4 * i), 1'b0, 1'b0);
      tick();
    end
    rdy = 1'b0;
    drive(1'b1, 32'hEE, 32'h40, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (push_ready !== 1'b0 || pop_valid !== 1'b0 || count !== 3'd2 || ovf_sticky !== 1'b0) begin
        failures++;
        $display("FAIL freeze_c%0d: got pr=%b pv=%b count=%0d ovf=%b want 0 0 2 0",
                 c, push_ready, pop_valid, count, ovf_sticky);
      end
      tick();
    end
    rdy = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (count !== 3'd2 || pop_inst !== 32'hE0) begin
      failures++;
      $display("FAIL freeze_after: got count=%0d head=%h want 2 e0", count, pop_inst);
    end
    tick();
    // Push in flight, then reset pulses between edges.
    drive(1'b1, 32'hF0, 32'h80, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL async_reset_count: got %0d want 0", count); end
    #1;
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_lost_push: got count=%0d pv=%b want 0 0", count, pop_valid);
    end
    tick();
  endtask

  // Randomized traffic against a queue-based reference model.
  typedef struct {
    logic [DATA_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              pred;
  } entry_t;

  task automatic test_random();
    entry_t model[$];
    logic   m_ovf;
    logic   e_push_ready, e_pop_valid, e_afull, do_push, do_pop;
    apply_reset();
    m_ovf = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy   = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 24) == 0);
      drive(($urandom_range(0, 2) != 0), $urandom, $urandom, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1));
      @(negedge clk);
      e_push_ready = rdy && !clear && (model.size() < DEPTH);
      e_pop_valid  = rdy && !clear && (model.size() > 0);
      e_afull      = (DEPTH - model.size()) <= AFULL_SLACK;
      checks++;
      if (push_ready !== e_push_ready || pop_valid !== e_pop_valid || almost_full !== e_afull ||
          count !== CNT_W'(model.size()) || ovf_sticky !== m_ovf) begin
        failures++;
        $display("FAIL rand_status_c%0d: got pr=%b pv=%b af=%b cnt=%0d ovf=%b want %b %b %b %0d %b",
                 cyc, push_ready, pop_valid, almost_full, count, ovf_sticky,
                 e_push_ready, e_pop_valid, e_afull, model.size(), m_ovf);
      end
      if (model.size() > 0) begin
        checks++;
        if (pop_inst !== model[0].inst || pop_pc !== model[0].pc || pop_pred !== model[0].pred) begin
          failures++;
          $display("FAIL rand_head_c%0d: got %h/%h/%b want %h/%h/%b", cyc, pop_inst, pop_pc, pop_pred,
                   model[0].inst, model[0].pc, model[0].pred);
        end
      end
      do_push = push_valid && e_push_ready;
      do_pop  = pop_ready && e_pop_valid;
      tick();
      if (clear) begin
        model.delete();
      end else if (rdy) begin
        if (push_valid && !e_push_ready) m_ovf = 1'b1;
        if (do_pop) void'(model.pop_front());
        if (do_push) model.push_back('{inst: push_inst, pc: push_pc, pred: push_pred});
      end
    end
    rdy = 1'b1; clear = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_empty_no_bypass();
    test_clear();
    test_freeze_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
